// File: rtl/life_board_ring.sv
`default_nettype none
// ============================================================================
// Module   : life_board_ring
// Brief    : Circulating X*Y Life board store with run/step/clear/randomise
//            modes and generation alignment to the ring origin.
// Revision : 1.0 - initial release
// ============================================================================
module life_board_ring #(
    parameter int          X          = 8,
    parameter int          Y          = 8,
    parameter int          LOG2X      = 3,
    parameter int          LOG2Y      = 3,
    parameter int          TAP_OFFSET = X + 3,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run,
    input  logic                   step,
    input  logic                   key_flip,
    input  logic                   key_clr,
    input  logic                   key_rand,
    input  logic [LOG2X-1:0]       cursor_x,
    input  logic [LOG2Y-1:0]       cursor_y,
    input  logic                   pipe_out,
    output logic                   cell_out,
    output logic [$clog2(X*Y)-1:0] pos,
    output logic [15:0]            gen_count,
    output logic                   gen_done,
    output logic                   busy
);

    localparam int              c_N    = X * Y;
    localparam int              c_PW   = $clog2(c_N);
    localparam int              c_AW   = c_PW + 2;
    localparam int              c_WB   = c_N - TAP_OFFSET;
    localparam logic [c_PW-1:0] c_LAST = c_PW'(c_N - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_EVOLVE = 2'd2,
        ST_RAND   = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [c_N-1:0]  r_data;
    logic [c_N-1:0]  w_data_next;
    logic [c_PW-1:0] r_pos;
    logic [c_PW-1:0] r_rand_cnt;
    logic [15:0]     r_gen_count;
    logic            r_gen_done;
    logic            r_busy;
    logic [15:0]     r_lfsr;
    logic            r_key_flip_d;
    logic            r_key_clr_d;
    logic            r_key_rand_d;

    logic            w_wrap;
    logic            w_clr_rise;
    logic            w_rand_rise;
    logic            w_flip_fall;
    logic            w_cursor_ok;
    logic [c_AW-1:0] w_cell_lin;
    logic [c_AW-1:0] w_flip_raw;
    logic [c_PW-1:0] w_flip_bit;
    logic            w_lfsr_fb;

    assign w_wrap      = (r_pos == c_LAST);
    assign w_clr_rise  = key_clr & ~r_key_clr_d;
    assign w_rand_rise = key_rand & ~r_key_rand_d;
    assign w_flip_fall = r_key_flip_d & ~key_flip;
    assign w_cursor_ok = (int'(cursor_x) < X) && (int'(cursor_y) < Y);

    // Physical slot that will hold the cursor's logical cell after this shift
    assign w_cell_lin = c_AW'(cursor_y) * c_AW'(X) + c_AW'(cursor_x);
    assign w_flip_raw = w_cell_lin + c_AW'(c_N - 1) - c_AW'(r_pos);
    assign w_flip_bit = c_PW'((w_flip_raw >= c_AW'(c_N)) ? (w_flip_raw - c_AW'(c_N))
                                                         : w_flip_raw);

    // Right-shift Fibonacci form of x^16 + x^14 + x^13 + x^11 + 1
    assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_rand_rise)
                    w_state_next = ST_RAND;
                else if (run || step)
                    // A request seen on the last position starts at the origin directly
                    w_state_next = w_wrap ? ST_EVOLVE : ST_ARMED;
            end
            ST_ARMED:  if (w_wrap) w_state_next = ST_EVOLVE;
            ST_EVOLVE: if (w_wrap && !run) w_state_next = ST_IDLE;
            ST_RAND:   if (r_rand_cnt == c_LAST) w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
        if (w_clr_rise)
            w_state_next = ST_IDLE;
    end

    always_comb begin
        w_data_next = {r_data[0], r_data[c_N-1:1]};
        if (r_state == ST_RAND)
            w_data_next[c_N-1] = r_lfsr[0];
        else if (r_state == ST_EVOLVE)
            w_data_next[c_WB] = pipe_out;
        else if (r_state == ST_IDLE && w_flip_fall && w_cursor_ok)
            w_data_next[w_flip_bit] = ~w_data_next[w_flip_bit];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data       <= '0;
            r_pos        <= '0;
            r_rand_cnt   <= '0;
            r_gen_count  <= 16'd0;
            r_gen_done   <= 1'b0;
            r_busy       <= 1'b0;
            r_lfsr       <= SEED;
            r_key_flip_d <= 1'b0;
            r_key_clr_d  <= 1'b0;
            r_key_rand_d <= 1'b0;
        end else begin
            r_pos        <= w_wrap ? '0 : r_pos + c_PW'(1);
            r_busy       <= (w_state_next != ST_IDLE);
            r_key_flip_d <= key_flip;
            r_key_clr_d  <= key_clr;
            r_key_rand_d <= key_rand;

            if (w_clr_rise) begin
                r_data      <= '0;
                r_gen_count <= 16'd0;
                r_gen_done  <= 1'b0;
            end else begin
                r_data     <= w_data_next;
                r_gen_done <= (r_state == ST_EVOLVE) && w_wrap;
                if ((r_state == ST_EVOLVE) && w_wrap)
                    r_gen_count <= r_gen_count + 16'd1;
            end

            if (r_state == ST_RAND && !w_clr_rise)
                r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};

            if (r_state == ST_RAND && r_rand_cnt != c_LAST && !w_clr_rise)
                r_rand_cnt <= r_rand_cnt + c_PW'(1);
            else
                r_rand_cnt <= '0;
        end
    end

    assign cell_out  = r_data[0];
    assign pos       = r_pos;
    assign gen_count = r_gen_count;
    assign gen_done  = r_gen_done;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: doc/life_board_ring.md
# life_board_ring

Full-board circulating cell store for the Life engine, generalising the original top-segment store to an arbitrary X×Y ring with run/step/clear/randomise modes. The board rotates one bit per clock; `cell_out` feeds the neighbour pipeline and the display scan, and `pipe_out` is written back at a fixed tap. A mode FSM aligns generations to the ring origin and counts completed generations. Cursor edits address logical cells independent of the current rotation.

## Interface
- `X`, 8: board width (cells).
- `Y`, 8: board height (cells); N = X*Y.
- `LOG2X`, 3: cursor_x width; X ≤ 2^LOG2X.
- `LOG2Y`, 3: cursor_y width.
- `TAP_OFFSET`, X+3: writeback bit index is N−TAP_OFFSET; range 1..N−1.
- `SEED`, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low.
- `run`  in  1  level; evolve continuously.
- `step`  in  1  pulse; request one generation when `run`=0.
- `key_flip`  in  1  flip key; acts on falling edge.
- `key_clr`  in  1  clear key; acts on rising edge.
- `key_rand`  in  1  randomise key; acts on rising edge.
- `cursor_x`  in  LOG2X  edit column.
- `cursor_y`  in  LOG2Y  edit row.
- `pipe_out`  in  1  next-generation cell value from the neighbour pipeline.
- `cell_out`  out  1  = data[0], the ring head.
- `pos`  out  ceil(log2 N)  logical index of the cell in data[0].
- `gen_count`  out  16  completed generations; wraps at 2^16.
- `gen_done`  out  1  one-cycle pulse per completed generation.
- `busy`  out  1  state ≠ IDLE.

## Operation
- Ring `data[N-1:0]` rotates right every cycle: data_next = {data[0], data[N-1:1]}. data[i] holds logical cell (pos+i) mod N. `pos` increments mod N each cycle, N−1 → 0.
- FSM states: IDLE, ARMED, EVOLVE, RAND.
  - IDLE → ARMED on `run`=1 or `step`=1.
  - ARMED → EVOLVE in the cycle pos wraps N−1 → 0.
  - EVOLVE: data_next[N−TAP_OFFSET] = pipe_out every cycle. At each wrap N−1 → 0: `gen_done`=1 and `gen_count`+1. The state then stays EVOLVE if `run`=1, otherwise goes to IDLE.
  - Dropping `run` mid-generation completes the current generation; there are no partial generations.
  - RAND: entered from IDLE on a `key_rand` rise, for exactly N cycles. It inserts the LFSR bit in place of data[0] at data_next[N−1]. The LFSR is 16-bit Fibonacci, taps 16,14,13,11, and advances only in RAND. Afterwards → IDLE.
- Clear: a `key_clr` rise in any state sets data <= 0, `gen_count` <= 0 and state <= IDLE in one cycle. An ARMED or EVOLVE request is cancelled and `gen_done` is not pulsed.
- Flip: only in IDLE. On `key_flip_d`=1 and `key_flip`=0, toggle data_next at physical index (cursor_y*X + cursor_x − pos − 1) mod N. If cursor_x ≥ X or cursor_y ≥ Y, the flip is ignored. A flip in any other state is dropped.
- Edge detectors `key_flip_d`, `key_clr_d` and `key_rand_d` are registered and reset to 0.
- Priority, highest first: reset, clear, RAND insert, EVOLVE writeback, flip.
- `step` in EVOLVE or RAND is ignored. `step` and `run` together are treated as `run`.

## Timing
- Reset values:
  - data = 0, pos = 0, gen_count = 0, gen_done = 0.
  - state = IDLE, busy = 0, LFSR = SEED.
  - edge registers = 0, cell_out = 0.
- All outputs are registered or direct register taps.
- `cell_out` is valid every cycle, including IDLE; the ring never stops.
- `step` → first writeback: 1 to N cycles, depending on pos.
- Generation length: exactly N cycles. `gen_done` is asserted in the cycle after the wrap, coincident with pos=0.
- A flip is visible on `cell_out` when pos equals the cursor index.
- Reset assertion mid-EVOLVE or mid-RAND returns to reset values immediately.

## Test plan
- Reset, then run 64 cycles idle (X=Y=8): cell_out=0, pos cycles 0..63, busy=0, gen_count=0.
- Cursor (2,1), release key_flip at pos=17: cell_out=1 exactly when pos=10; the other 63 positions read 0.
- `step` at pos=5, pipe_out tied 1: busy rises and EVOLVE starts at pos=0. After 64 cycles gen_done pulses once, gen_count=1 and busy=0. Next pass shows bit 53 onward overwritten with 1.
- `run`=1 for 3 generations, drop `run` at pos=30: EVOLVE continues to the wrap, gen_count=3, gen_done pulses exactly 3 times.
- `key_rand` rise: busy for 64 cycles, the ring matches the SEED-derived LFSR sequence, and a repeat after reset gives an identical board.
- `key_clr` rise during EVOLVE: next cycle data=0, gen_count=0, state IDLE, no gen_done. A flip issued during RAND is dropped.
